// File: rtl/as6d_vp_buffer_pkg.sv
// Shared widths, state encoding and ratio helper for the as6d video-path FIFO buffer.
package as6d_vp_buffer_pkg;

    localparam int AS6D_VP_BUF_DW  = 128;
    localparam int AS6D_VP_STRM_DW = 32;
    localparam int AS6D_VP_CNT_W   = 16;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_e;

    function automatic int calc_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/as6d_vp_wrap_cnt.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module as6d_vp_wrap_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: async reset, sync clear, silent wrap at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc) begin
            cnt_r <= cnt_r + WIDTH'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/as6d_vp_buffer_fwft_rd_unpacker.sv
// Pops FWFT FIFO words and serialises each into RATIO beats, low lane first,
// with the word's double-error flag attached to every beat.
module as6d_vp_buffer_fwft_rd_unpacker
    import as6d_vp_buffer_pkg::*;
#(
    parameter int IN_WIDTH  = AS6D_VP_BUF_DW,
    parameter int OUT_WIDTH = AS6D_VP_STRM_DW,
    parameter int CNT_WIDTH = AS6D_VP_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_clr,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    input  logic                 fifo_rd_data_val,
    input  logic                 fifo_double_err,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_err,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 busy
);

    localparam int RATIO  = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    unpack_state_e        state_r;
    logic [LANE_W-1:0]    lane_r;
    logic [IN_WIDTH-1:0]  hold_r;
    logic                 err_r;

    logic                 hold_val_s;
    logic                 lane_last_s;
    logic                 accept_s;
    logic                 last_acc_s;
    logic                 pop_s;
    logic [OUT_WIDTH-1:0] lane_data_s [RATIO];

    assign hold_val_s  = (state_r == ST_DRAIN);
    assign lane_last_s = (lane_r == LAST_LANE);
    assign accept_s    = hold_val_s & out_ready;
    assign last_acc_s  = accept_s & lane_last_s;
    // A new word may be taken while the final beat of the held one is accepted.
    assign pop_s       = enable & fifo_rd_data_val & ~soft_clr & (~hold_val_s | last_acc_s);

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lane_data_s[g] = hold_r[g*OUT_WIDTH +: OUT_WIDTH];
    end

    // Hold-word FSM: EMPTY/DRAIN with lane index, flush has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            lane_r  <= '0;
            hold_r  <= '0;
            err_r   <= 1'b0;
        end else if (soft_clr) begin
            state_r <= ST_EMPTY;
            lane_r  <= '0;
            hold_r  <= '0;
            err_r   <= 1'b0;
        end else if (pop_s) begin
            state_r <= ST_DRAIN;
            lane_r  <= '0;
            hold_r  <= fifo_rd_data;
            err_r   <= fifo_double_err;
        end else if (last_acc_s) begin
            state_r <= ST_EMPTY;
            lane_r  <= '0;
            hold_r  <= hold_r;
            err_r   <= err_r;
        end else if (accept_s) begin
            state_r <= state_r;
            lane_r  <= lane_r + LANE_W'(1'b1);
            hold_r  <= hold_r;
            err_r   <= err_r;
        end else begin
            state_r <= state_r;
            lane_r  <= lane_r;
            hold_r  <= hold_r;
            err_r   <= err_r;
        end
    end

    as6d_vp_wrap_cnt #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (soft_clr),
        .inc   (accept_s),
        .cnt   (beat_cnt)
    );

    as6d_vp_wrap_cnt #(.WIDTH(CNT_WIDTH)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (soft_clr),
        .inc   (pop_s),
        .cnt   (word_cnt)
    );

    assign fifo_rd_en = pop_s;
    assign out_valid  = hold_val_s;
    assign out_data   = lane_data_s[lane_r];
    assign out_last   = lane_last_s;
    assign out_err    = err_r;
    assign busy       = hold_val_s;

endmodule

// File: tb/tb_as6d_vp_buffer_fwft_rd_unpacker.sv
// Directed bench: a queue-backed FWFT FIFO feeds the unpacker; beats are checked against hand-derived lanes.
module tb_as6d_vp_buffer_fwft_rd_unpacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         soft_clr;
    logic         enable;
    logic [127:0] fifo_rd_data;
    logic         fifo_rd_data_val;
    logic         fifo_double_err;
    logic         fifo_rd_en;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         out_err;
    logic [15:0]  beat_cnt;
    logic [15:0]  word_cnt;
    logic         busy;

    logic [127:0] q_data [$];
    logic         q_err  [$];
    int           n_cmp = 0;
    int           n_mis = 0;

    as6d_vp_buffer_fwft_rd_unpacker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .soft_clr         (soft_clr),
        .enable           (enable),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_data_val (fifo_rd_data_val),
        .fifo_double_err  (fifo_double_err),
        .fifo_rd_en       (fifo_rd_en),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .out_err          (out_err),
        .beat_cnt         (beat_cnt),
        .word_cnt         (word_cnt),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_rd_data_val = (q_data.size() > 0);
        fifo_rd_data     = (q_data.size() > 0) ? q_data[0] : 128'd0;
        fifo_double_err  = (q_err.size() > 0) ? q_err[0] : 1'b0;
    endtask

    task automatic push(input logic [127:0] w, input logic e);
        q_data.push_back(w);
        q_err.push_back(e);
        fifo_refresh();
    endtask

    // Called after the negedge: sample the pop strobe, cross the posedge, pop the model FIFO.
    task automatic finish_cycle();
        logic rd_q;
        rd_q = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd_q && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_err.pop_front());
        end
        fifo_refresh();
    endtask

    function automatic logic [127:0] mkword(input logic [15:0] id);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[k*32 +: 32] = {8'hC3, id, 8'(k)};
        return w;
    endfunction

    task automatic beat_chk(input string tag, input logic [31:0] d, input logic last,
                            input logic e, input logic rd);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(d));
        check({tag, "_last"},  64'(out_last),  64'(last));
        check({tag, "_err"},   64'(out_err),   64'(e));
        check({tag, "_rden"},  64'(fifo_rd_en), 64'(rd));
    endtask

    task automatic stream_word(input string tag, input logic [127:0] w, input logic e, input logic pop_last);
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            beat_chk($sformatf("%s_b%0d", tag, k), w[k*32 +: 32], (k == 3), e, (k == 3) ? pop_last : 1'b0);
            finish_cycle();
        end
    endtask

    task automatic idle_pop(input string tag, input logic rd);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rden"},  64'(fifo_rd_en), 64'(rd));
        finish_cycle();
    endtask

    task automatic cnt_chk(input string tag, input logic [15:0] w, input logic [15:0] b);
        @(negedge clk);
        check({tag, "_words"}, 64'(word_cnt), 64'(w));
        check({tag, "_beats"}, 64'(beat_cnt), 64'(b));
    endtask

    logic [127:0] w_s;
    logic [31:0]  lane_exp [4];

    initial begin
        rst_n = 1'b0; soft_clr = 1'b0; enable = 1'b0; out_ready = 1'b0;
        fifo_refresh();

        // Reset state
        @(negedge clk);
        check("rst_rden",  64'(fifo_rd_en), 64'd0);
        check("rst_valid", 64'(out_valid),  64'd0);
        check("rst_data",  64'(out_data),   64'd0);
        check("rst_last",  64'(out_last),   64'd0);
        check("rst_err",   64'(out_err),    64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_wcnt",  64'(word_cnt),   64'd0);
        check("rst_bcnt",  64'(beat_cnt),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;

        // Single word, hand-computed lanes
        lane_exp = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        push(128'h33333333_22222222_11111111_00000000, 1'b0);
        idle_pop("single_pop", 1'b1);
        for (int k = 0; k < 4; k++) begin
            beat_chk($sformatf("single_b%0d", k), lane_exp[k], (k == 3), 1'b0, 1'b0);
            check("single_busy", 64'(busy), 64'd1);
            finish_cycle();
        end
        idle_pop("single_after", 1'b0);
        cnt_chk("single_cnt", 16'd1, 16'd4);
        finish_cycle();

        // Back-to-back: 8 words, 32 gap-free beats, pop exactly on lane 3
        for (int i = 0; i < 8; i++) push(mkword(16'(i)), 1'b0);
        idle_pop("b2b_pop", 1'b1);
        for (int i = 0; i < 8; i++) stream_word($sformatf("b2b_w%0d", i), mkword(16'(i)), 1'b0, (i < 7));
        idle_pop("b2b_after", 1'b0);
        cnt_chk("b2b_cnt", 16'd9, 16'd36);
        finish_cycle();

        // Backpressure: ready 1,0,0,1 mid-word with a second word waiting
        push(mkword(16'h0100), 1'b0);
        push(mkword(16'h0101), 1'b0);
        w_s = mkword(16'h0100);
        idle_pop("bp_pop", 1'b1);
        out_ready = 1'b1; beat_chk("bp_c1", w_s[31:0], 1'b0, 1'b0, 1'b0); finish_cycle();
        out_ready = 1'b0; beat_chk("bp_c2", w_s[63:32], 1'b0, 1'b0, 1'b0);
        check("bp_c2_bcnt", 64'(beat_cnt), 64'd37); finish_cycle();
        out_ready = 1'b0; beat_chk("bp_c3", w_s[63:32], 1'b0, 1'b0, 1'b0);
        check("bp_c3_bcnt", 64'(beat_cnt), 64'd37); finish_cycle();
        out_ready = 1'b1; beat_chk("bp_c4", w_s[63:32], 1'b0, 1'b0, 1'b0); finish_cycle();
        beat_chk("bp_c5", w_s[95:64], 1'b0, 1'b0, 1'b0); finish_cycle();
        beat_chk("bp_c6", w_s[127:96], 1'b1, 1'b0, 1'b1); finish_cycle();
        stream_word("bp_w2", mkword(16'h0101), 1'b0, 1'b0);
        idle_pop("bp_after", 1'b0);
        cnt_chk("bp_cnt", 16'd11, 16'd44);
        finish_cycle();

        // ECC flag on the middle word only
        push(mkword(16'h0200), 1'b0);
        push(mkword(16'h0201), 1'b1);
        push(mkword(16'h0202), 1'b0);
        idle_pop("ecc_pop", 1'b1);
        stream_word("ecc_w1", mkword(16'h0200), 1'b0, 1'b1);
        stream_word("ecc_w2", mkword(16'h0201), 1'b1, 1'b1);
        stream_word("ecc_w3", mkword(16'h0202), 1'b0, 1'b0);
        cnt_chk("ecc_cnt", 16'd14, 16'd56);
        finish_cycle();

        // soft_clr at lane 2 flushes the word and counters
        push(mkword(16'h0300), 1'b0);
        push(mkword(16'h0301), 1'b0);
        w_s = mkword(16'h0300);
        idle_pop("clr_pop", 1'b1);
        beat_chk("clr_b0", w_s[31:0], 1'b0, 1'b0, 1'b0); finish_cycle();
        beat_chk("clr_b1", w_s[63:32], 1'b0, 1'b0, 1'b0); finish_cycle();
        soft_clr = 1'b1;
        beat_chk("clr_b2", w_s[95:64], 1'b0, 1'b0, 1'b0); finish_cycle();
        soft_clr = 1'b0;
        cnt_chk("clr_next", 16'd0, 16'd0);
        check("clr_next_valid", 64'(out_valid), 64'd0);
        check("clr_next_busy",  64'(busy),      64'd0);
        check("clr_next_rden",  64'(fifo_rd_en), 64'd1);
        finish_cycle();
        stream_word("clr_w2", mkword(16'h0301), 1'b0, 1'b0);
        cnt_chk("clr_cnt", 16'd1, 16'd4);
        finish_cycle();

        // enable dropped at lane 1: word completes, no further pops
        push(mkword(16'h0400), 1'b0);
        push(mkword(16'h0401), 1'b0);
        w_s = mkword(16'h0400);
        idle_pop("en_pop", 1'b1);
        beat_chk("en_b0", w_s[31:0], 1'b0, 1'b0, 1'b0); finish_cycle();
        enable = 1'b0;
        beat_chk("en_b1", w_s[63:32], 1'b0, 1'b0, 1'b0); finish_cycle();
        beat_chk("en_b2", w_s[95:64], 1'b0, 1'b0, 1'b0); finish_cycle();
        beat_chk("en_b3", w_s[127:96], 1'b1, 1'b0, 1'b0); finish_cycle();
        for (int i = 0; i < 3; i++) idle_pop("en_hold", 1'b0);
        enable = 1'b1;
        idle_pop("en_resume", 1'b1);
        stream_word("en_w2", mkword(16'h0401), 1'b0, 1'b0);
        cnt_chk("en_cnt", 16'd3, 16'd12);
        finish_cycle();

        // Asynchronous reset mid-word drops the word; the model FIFO is re-initialised
        push(mkword(16'h0500), 1'b0);
        idle_pop("ar_pop", 1'b1);
        w_s = mkword(16'h0500);
        beat_chk("ar_b0", w_s[31:0], 1'b0, 1'b0, 1'b0); finish_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_busy",  64'(busy),      64'd0);
        check("ar_wcnt",  64'(word_cnt),  64'd0);
        q_data.delete(); q_err.delete(); fifo_refresh();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Counter wrap: 65536 accepted beats bring beat_cnt back to 0
        for (int i = 0; i < 16384; i++) push(mkword(16'(i)), 1'b0);
        idle_pop("wrap_pop", 1'b1);
        for (int b = 0; b < 65536; b++) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (b == 65535) begin
                check("wrap_pre", 64'(beat_cnt), 64'hFFFF);
                check("wrap_last_data", 64'(out_data), 64'h C33FFF03);
            end
            finish_cycle();
        end
        @(negedge clk);
        check("wrap_bcnt",  64'(beat_cnt),  64'd0);
        check("wrap_wcnt",  64'(word_cnt),  64'd16384);
        check("wrap_valid", 64'(out_valid), 64'd0);
        check("wrap_err",   64'(out_err),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
